// File: rtl/hazard_unit_pkg.sv
// Shared CPU definitions used by the hazard unit: opcode constants, forwarding
// select encodings, tracker entry layout and opcode classification helpers.
package hazard_unit_pkg;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } trk_entry_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_OP)  || (op == OP_IMM)   || (op == OP_LOAD) ||
           (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL)  ||
           (op == OP_JALR);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_OP)    || (op == OP_IMM)    || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_unit_match.sv
// Compares one ID source register against one tracker entry; x0 never matches.
module hazard_match (
  input  logic       src_used,
  input  logic [4:0] src_addr,
  input  logic       ent_valid,
  input  logic [4:0] ent_rd,
  output logic       hit
);

  assign hit = src_used && (src_addr != 5'd0) && ent_valid && (ent_rd == src_addr);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB destinations, raises load-use stalls
// and redirect flushes, and registers operand forwarding for the issuing op.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_redirect,
  output logic             stall_if,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  trk_entry_t ex_q, ex_d, mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic use_a, use_b;
  logic [2:0] hit_a, hit_b;   // index 0 = EX, 1 = MEM, 2 = WB
  trk_entry_t ent [3];
  logic load_use;

  assign use_a = id_valid && reads_rs1(id_opcode);
  assign use_b = id_valid && reads_rs2(id_opcode);

  assign ent[0] = ex_q;
  assign ent[1] = mem_q;
  assign ent[2] = wb_q;

  for (genvar g = 0; g < 3; g++) begin : g_match
    hazard_match u_match_a (
      .src_used  (use_a),
      .src_addr  (id_rs1),
      .ent_valid (ent[g].valid),
      .ent_rd    (ent[g].rd),
      .hit       (hit_a[g])
    );
    hazard_match u_match_b (
      .src_used  (use_b),
      .src_addr  (id_rs2),
      .ent_valid (ent[g].valid),
      .ent_rd    (ent[g].rd),
      .hit       (hit_b[g])
    );
  end

  assign load_use = ex_q.is_load && (hit_a[0] || hit_b[0]);

  // WB-only matches stay on the regfile path: it writes before it reads.
  function automatic logic [1:0] fwd_pick(input logic [2:0] hits);
    if (hits[0])      return FWD_MEM;
    else if (hits[1]) return FWD_WB;
    else if (hits[2]) return FWD_RF;
    else              return FWD_RF;
  endfunction

  always_comb begin
    stall_if  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    if (!rst) begin
      flush_id  = ex_redirect;
      bubble_ex = ex_redirect || load_use;
      stall_if  = load_use && !ex_redirect;
    end
  end

  always_comb begin
    ex_d        = '0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_if);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_id);
    if (id_valid && !bubble_ex) begin
      ex_d.valid   = writes_rd(id_opcode);
      ex_d.rd      = id_rd;
      ex_d.is_load = (id_opcode == OP_LOAD);
      fwd_a_d      = fwd_pick(hit_a);
      fwd_b_d      = fwd_pick(hit_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations plus randomized traffic against a history-based model.
module tb_hazard_unit;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic             ex_redirect;
  logic             stall_if, flush_id, bubble_ex;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_redirect (ex_redirect),
    .stall_if    (stall_if),
    .flush_id    (flush_id),
    .bubble_ex   (bubble_ex),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of the last three issued instructions (0 = youngest, in EX).
  bit        m_w  [3];
  bit [4:0]  m_rd [3];
  bit        m_ld [3];
  int        m_fa, m_fb;
  bit [15:0] m_sc, m_fc;

  bit obs_stall, obs_flush, obs_bubble;

  function automatic bit is_wr(input bit [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
  endfunction
  function automatic bit is_r1(input bit [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic bit is_r2(input bit [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit dep(input bit [4:0] s, input int age);
    return (s != 5'd0) && m_w[age] && (m_rd[age] == s);
  endfunction

  // Youngest producer wins; a WB-stage producer is already visible in the regfile.
  function automatic int fsel(input bit used, input bit [4:0] s);
    if (!used)     return 0;
    if (dep(s, 0)) return 2;
    if (dep(s, 1)) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_w[i] = 0; m_rd[i] = 0; m_ld[i] = 0;
    end
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic step(input bit v, input bit [6:0] op, input bit [4:0] rd,
                      input bit [4:0] rs1, input bit [4:0] rs2, input bit redir);
    bit ua, ub, lu, e_stall, e_flush, e_bub;
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_redirect = redir;
    ua = v && is_r1(op);
    ub = v && is_r2(op);
    lu = m_ld[0] && ((ua && dep(rs1, 0)) || (ub && dep(rs2, 0)));
    e_flush = redir;
    e_bub   = redir || lu;
    e_stall = lu && !redir;
    @(negedge clk);
    obs_stall = stall_if; obs_flush = flush_id; obs_bubble = bubble_ex;
    chk("stall_if",  int'(stall_if),  int'(e_stall));
    chk("flush_id",  int'(flush_id),  int'(e_flush));
    chk("bubble_ex", int'(bubble_ex), int'(e_bub));
    chk("fwd_a",     int'(fwd_a),     m_fa);
    chk("fwd_b",     int'(fwd_b),     m_fb);
    chk("stall_cnt", int'(stall_cnt), int'(m_sc));
    chk("flush_cnt", int'(flush_cnt), int'(m_fc));
    @(posedge clk);
    if (v && !e_bub) begin
      m_fa = fsel(ua, rs1);
      m_fb = fsel(ub, rs2);
    end else begin
      m_fa = 0; m_fb = 0;
    end
    for (int i = 2; i > 0; i--) begin
      m_w[i] = m_w[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
    end
    m_w[0]  = v && !e_bub && is_wr(op);
    m_rd[0] = rd;
    m_ld[0] = v && !e_bub && (op == 7'h03);
    if (e_stall) m_sc = m_sc + 16'd1;
    if (e_flush) m_fc = m_fc + 16'd1;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  int'(stall_if),  0);
    chk({tag, "_flush"},  int'(flush_id),  0);
    chk({tag, "_bubble"}, int'(bubble_ex), 0);
    chk({tag, "_fwd_a"},  int'(fwd_a),     0);
    chk({tag, "_fwd_b"},  int'(fwd_b),     0);
    chk({tag, "_scnt"},   int'(stall_cnt), 0);
    chk({tag, "_fcnt"},   int'(flush_cnt), 0);
  endtask

  bit [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67,
                         7'h23, 7'h63, 7'h00, 7'h7F};

  initial begin
    rst = 1'b1; id_valid = 0; id_opcode = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    ex_redirect = 1'b1;
    m_reset();
    #12;
    chk_all_zero("reset");
    ex_redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // lw x5 ; add x6,x5,x7 -> one stall, then fwd_a=01
    step(1, 7'h03, 5, 1, 0, 0);
    step(1, 7'h33, 6, 5, 7, 0);
    chk("lu_stall",  int'(obs_stall),  1);
    chk("lu_bubble", int'(obs_bubble), 1);
    chk("lu_scnt",   int'(stall_cnt),  1);
    step(1, 7'h33, 6, 5, 7, 0);
    chk("lu_nostall", int'(obs_stall), 0);
    chk("lu_fwd_a",   int'(fwd_a),     1);
    chk("lu_fwd_b",   int'(fwd_b),     0);

    // addi x3,x0,1 ; sub x4,x3,x3 -> fwd 10/10
    step(1, 7'h13, 3, 0, 0, 0);
    step(1, 7'h33, 4, 3, 3, 0);
    chk("alu_stall", int'(obs_stall), 0);
    chk("alu_fwd_a", int'(fwd_a), 2);
    chk("alu_fwd_b", int'(fwd_b), 2);

    // beq x1,x2 (rd 31) ; add x8,x31,x31 -> no dependency
    step(1, 7'h63, 31, 1, 2, 0);
    step(1, 7'h33, 8, 31, 31, 0);
    chk("br_stall", int'(obs_stall), 0);
    chk("br_fwd_a", int'(fwd_a), 0);
    chk("br_fwd_b", int'(fwd_b), 0);

    // load-use coinciding with redirect: redirect wins
    step(1, 7'h03, 5, 1, 0, 0);
    step(1, 7'h33, 6, 5, 7, 1);
    chk("rd_flush",  int'(obs_flush),  1);
    chk("rd_bubble", int'(obs_bubble), 1);
    chk("rd_stall",  int'(obs_stall),  0);
    chk("rd_scnt",   int'(stall_cnt),  1);
    chk("rd_fcnt",   int'(flush_cnt),  1);
    chk("rd_fwd_a",  int'(fwd_a),      0);

    // add x0,x1,x2 ; add x9,x0,x0 -> x0 never forwards
    step(1, 7'h33, 0, 1, 2, 0);
    step(1, 7'h33, 9, 0, 0, 0);
    chk("x0_stall", int'(obs_stall), 0);
    chk("x0_fwd_a", int'(fwd_a), 0);
    chk("x0_fwd_b", int'(fwd_b), 0);

    // reset pulsed during a load-use stall (with a redirect pending too)
    step(1, 7'h03, 5, 1, 0, 0);
    id_valid = 1; id_opcode = 7'h33; id_rd = 6; id_rs1 = 5; id_rs2 = 7;
    @(negedge clk);
    chk("pre_rst_stall", int'(stall_if), 1);
    #1 rst = 1'b1; ex_redirect = 1'b1;
    #1 chk_all_zero("rst_async");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    id_valid = 0; ex_redirect = 0;
    rst = 1'b0;
    m_reset();
    step(1, 7'h33, 6, 5, 7, 0);
    chk("post_rst_bubble", int'(obs_bubble), 0);
    chk("post_rst_stall",  int'(obs_stall),  0);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) != 0),
           ops[$urandom_range(0, 10)],
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
